// File: rtl/regdump_pkg.sv
// Shared constants and FSM state encoding for the register-file dump sequencer.
// Default regfile geometry is exported for other regfile users.
package regdump_pkg;

    localparam int unsigned REGDUMP_ADDR_W = 5;
    localparam int unsigned REGDUMP_DATA_W = 32;

    // Dump sequencer states; ST_CSUM is only reachable with REGDUMP_CHECKSUM_EN defined.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_CSUM,
        ST_FIN
    } regdump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// regfile_dump: read-side sequencer that walks FIRST_REG..LAST_REG through one
// combinational regfile read port and streams each word out on valid/ready,
// tagged with its address.
// Optional feature: define REGDUMP_CHECKSUM_EN to append an XOR checksum word
// (address all-ones, out_last=1) after the LAST_REG word.
module regfile_dump
    import regdump_pkg::*;
#(
    parameter int unsigned ADDR_W    = REGDUMP_ADDR_W,
    parameter int unsigned DATA_W    = REGDUMP_DATA_W,
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    regdump_state_t    state;
    regdump_state_t    state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              hs;
    logic              at_last;

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc;
`endif

    assign ra      = cnt;
    assign hs      = out_valid && out_ready;
    // Termination is by compare so LAST_REG == 2**ADDR_W-1 never relies on wrap.
    assign at_last = (cnt == LAST_A);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one LOAD per word, SEND waits for the handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_SEND;
            ST_SEND: begin
                if (hs) begin
                    if (!at_last) begin
                        state_nxt = ST_LOAD;
                    end else begin
`ifdef REGDUMP_CHECKSUM_EN
                        state_nxt = ST_CSUM;
`else
                        state_nxt = ST_FIN;
`endif
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            ST_CSUM: if (hs) state_nxt = ST_FIN;
`endif
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs: capture in LOAD, hold through SEND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= FIRST_A;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            acc       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt  <= FIRST_A;
                        busy <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                        acc  <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    out_data  <= rd;
                    out_addr  <= cnt;
                    out_valid <= 1'b1;
                    out_last  <= at_last && !CSUM_EN;
                end
                ST_SEND: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        if (!at_last) begin
                            cnt <= cnt + ADDR_W'(1);
                        end
`ifdef REGDUMP_CHECKSUM_EN
                        acc <= acc ^ out_data;
                        // Checksum word is presented straight from the final handshake,
                        // folding the last data word in on the way.
                        if (at_last) begin
                            out_data  <= acc ^ out_data;
                            out_addr  <= '1;
                            out_last  <= 1'b1;
                            out_valid <= 1'b1;
                        end
`endif
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (hs) out_valid <= 1'b0;
                end
`endif
                ST_FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
